wb_arb2: RTL and testbench
==========================

WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter ADR_W, default 32, address width.
REQ-002 SHALL have parameter DAT_W, default 32, data width; SEL width = DAT_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles a granted strobe may wait for ack/err (1..65535).
REQ-004 SHALL have clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have mN_cyc, mN_stb, mN_we  in  1 each  master N (N=0 instruction, N=1 data) cycle, strobe, write-enable.
REQ-007 SHALL have mN_adr  in  ADR_W; mN_sel  in  SEL; mN_dat_w  in  DAT_W  master N request payload.
REQ-008 SHALL have mN_dat_r  out  DAT_W; mN_ack, mN_err  out  1  master N response.
REQ-009 SHALL have s_cyc, s_stb, s_we  out  1; s_adr  out  ADR_W; s_sel  out  SEL; s_dat_w  out  DAT_W  shared-slave request.
REQ-010 SHALL have s_dat_r  in  DAT_W; s_ack, s_err  in  1  shared-slave response.
REQ-011 SHALL have gnt  out  2  one-hot current owner (debug/monitor).
REQ-012 SHALL have timeout_cnt  out  16  saturating count of watchdog aborts.

Function
REQ-013 SHALL implement states IDLE, OWN0, OWN1, ABORT.
REQ-014 IDLE: if exactly one mN_cyc high -> OWNN next cycle; if both high -> grant the master not granted last (round-robin pointer, reset value 1 so m0 wins first tie).
REQ-015 OWNN: slave request signals SHALL combinationally mirror master N; other master sees ack=err=0 and dat_r=s_dat_r.
REQ-016 OWNN: ownership SHALL persist while mN_cyc=1 (multi-beat/locked cycles never split); mN_cyc=0 -> IDLE, pointer updated to N.
REQ-017 In IDLE and ABORT, s_cyc=s_stb=0 and all mN_ack/mN_err=0.
REQ-018 mN_ack=s_ack & gnt[N] & mN_stb, mN_err likewise from s_err; zero added latency in the response path.
REQ-019 Arbitration latency: request in IDLE -> s_cyc asserted the following cycle; back-to-back owner switch costs exactly one IDLE cycle.
REQ-020 Watchdog counter SHALL clear on entering OWNN and on every s_ack/s_err, increment each cycle s_stb=1 without response.
REQ-021 When watchdog reaches TIMEOUT: mN_err=1 for exactly one cycle (s_cyc/s_stb forced 0 same cycle), go to ABORT, timeout_cnt+1 saturating at 16'hFFFF.
REQ-022 ABORT: hold until owning mN_cyc=0, then IDLE; a late s_ack during ABORT SHALL be dropped.
REQ-023 s_ack and watchdog expiry in the same cycle: ack wins, no err, counter clears.
REQ-024 mN_cyc dropping mid-strobe (master abort) SHALL release ownership next cycle without error.

Reset
REQ-025 On reset low: state=IDLE, gnt=2'b00, pointer=1, watchdog=0, timeout_cnt=0, all s_* and mN_ack/mN_err outputs 0, mN_dat_r=s_dat_r.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately (asynchronously); no ack/err emitted after release until a new grant.

Structure
REQ-027 State encoding, TIMEOUT default and SEL width function SHALL live in shared package wb_pkg.
REQ-028 Watchdog SHALL be sub-module wb_watchdog (clk, reset, clr, en, expired); arbitration FSM and muxing stay in wb_arb2.

Verification
REQ-029 Single request: m1 write adr=0x1000_0004 dat=0xDEADBEEF, slave acks 2 cycles after s_stb -> s_* mirror m1, m1_ack one cycle, gnt=2'b10, m0 sees no ack.
REQ-030 Tie: m0 and m1 request same cycle from reset -> m0 granted first; after m0_cyc drops, m1 granted after one IDLE cycle; second tie -> m0 (alternation).
REQ-031 Locked burst: m0 holds cyc for 4 acked strobes while m1 requests -> m1 not granted until m0_cyc=0.
REQ-032 Timeout: TIMEOUT=8, slave never acks -> m0_err pulse at 8th stb cycle, s_cyc=0, timeout_cnt=1, late s_ack in ABORT ignored.
REQ-033 Ack at expiry: s_ack on watchdog cycle 8 -> m0_ack=1, m0_err=0, timeout_cnt unchanged.
REQ-034 Reset mid-transaction (m1 owning, stb pending) -> outputs zero, gnt=0, next request resolves as from fresh reset (m0 wins tie).

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam int TIMEOUT_DEF = 255;

    function automatic int sel_width(input int dat_w);
        return dat_w / 8;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - counts unanswered strobe cycles and flags expiry
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Fires during the TIMEOUT-th unanswered strobe cycle itself.
    assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - round-robin two-master Wishbone arbiter with strobe watchdog
module wb_arb2
    import wb_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int SEL_W  = sel_width(DAT_W)
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [SEL_W-1:0] m0_sel,
    input  logic [DAT_W-1:0] m0_dat_w,
    output logic [DAT_W-1:0] m0_dat_r,
    output logic             m0_ack,
    output logic             m0_err,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [SEL_W-1:0] m1_sel,
    input  logic [DAT_W-1:0] m1_dat_w,
    output logic [DAT_W-1:0] m1_dat_r,
    output logic             m1_ack,
    output logic             m1_err,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [SEL_W-1:0] s_sel,
    output logic [DAT_W-1:0] s_dat_w,
    input  logic [DAT_W-1:0] s_dat_r,
    input  logic             s_ack,
    input  logic             s_err,

    output logic [1:0]       gnt,
    output logic [15:0]      timeout_cnt
);

    arb_state_t state, state_nxt;
    logic       ptr;
    logic       owner;
    logic       req_cyc, req_stb;
    logic       own0, own1;
    logic       resp;
    logic       wd_clr, wd_en, expired;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= 1'b1;
            owner       <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                owner <= (state_nxt == ST_OWN1);
            end
            // ptr remembers the last owner so the other master wins the next tie
            if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                ptr <= owner;
            end
            if (expired && timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nxt = ptr ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc) begin
                    state_nxt = ST_OWN0;
                end else if (m1_cyc) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc) begin
                    state_nxt = ST_IDLE;
                end else if (expired) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc) begin
                    state_nxt = ST_IDLE;
                end else if (expired) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (!(owner ? m1_cyc : m0_cyc)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_cyc = 1'b0;
        req_stb = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_sel   = '0;
        s_dat_w = '0;
        gnt     = 2'b00;
        unique case (state)
            ST_OWN0: begin
                req_cyc = m0_cyc;
                req_stb = m0_cyc & m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_sel   = m0_sel;
                s_dat_w = m0_dat_w;
                gnt     = 2'b01;
            end
            ST_OWN1: begin
                req_cyc = m1_cyc;
                req_stb = m1_cyc & m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_sel   = m1_sel;
                s_dat_w = m1_dat_w;
                gnt     = 2'b10;
            end
            ST_ABORT: gnt = owner ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign resp   = s_ack | s_err;
    assign wd_en  = req_stb & ~resp;
    assign wd_clr = ~(own0 | own1) | resp;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (expired)
    );

    // The expiry cycle withdraws the request from the slave immediately.
    assign s_cyc = req_cyc & ~expired;
    assign s_stb = req_stb & ~expired;

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;
    assign m0_ack   = s_ack & own0 & m0_stb;
    assign m1_ack   = s_ack & own1 & m1_stb;
    assign m0_err   = own0 & ((s_err & m0_stb) | expired);
    assign m1_err   = own1 & ((s_err & m1_stb) | expired);

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - scoreboard bench for wb_arb2 with directed vectors
module tb_wb_arb2;

    localparam logic [31:0] K = 32'h5A5A_5A5A;

    typedef struct {
        logic        err;
        logic [31:0] adr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat_w [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m0_dat_r, m1_dat_r;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w;
    logic [31:0] s_dat_r = 32'h0;
    logic [3:0]  s_sel;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [1:0]  gnt;
    logic [15:0] timeout_cnt;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q [2][$];

    bit          slave_auto = 1'b0;
    int          lat = 0;
    int          wcnt = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_dat = 32'hA5A5_0001;

    wb_arb2 #(.ADR_W(32), .DAT_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
        .m0_sel(m_sel[0]), .m0_dat_w(m_dat_w[0]), .m0_dat_r(m0_dat_r),
        .m0_ack(m_ack[0]), .m0_err(m_err[0]),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
        .m1_sel(m_sel[1]), .m1_dat_w(m_dat_w[1]), .m1_dat_r(m1_dat_r),
        .m1_ack(m_ack[1]), .m1_err(m_err[1]),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .gnt(gnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Slave: acks after `lat` unanswered strobe cycles, or replays manual values.
    always @(posedge clk) begin
        #2;
        if (slave_auto) begin
            if (s_cyc && s_stb) begin
                if (lat >= 0 && wcnt == lat) begin
                    s_ack   = 1'b1;
                    s_dat_r = s_adr ^ K;
                    wcnt    = 0;
                end else begin
                    s_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                s_ack = 1'b0;
                wcnt  = 0;
            end
        end else begin
            s_ack   = man_ack;
            s_dat_r = man_dat;
            wcnt    = 0;
        end
    end

    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (m_ack[n] | m_err[n]) begin
                if (exp_q[n].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp_m%0d: got ack=%b err=%b required none", n, m_ack[n], m_err[n]);
                end else begin
                    exp_t e;
                    e = exp_q[n].pop_front();
                    chk($sformatf("resp_kind_m%0d", n), {30'b0, m_err[n], m_ack[n]}, e.err ? 32'd2 : 32'd1);
                    chk($sformatf("other_quiet_m%0d", n), {30'b0, m_err[1-n], m_ack[1-n]}, 32'd0);
                    if (!e.err) begin
                        chk($sformatf("ack_adr_m%0d", n), s_adr, e.adr);
                        chk($sformatf("dat_r_m%0d", n), (n == 1) ? m1_dat_r : m0_dat_r, e.adr ^ K);
                    end
                end
            end
        end
    end

    task automatic master_access(input int n, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input int beats);
        exp_t e;
        bit   got;
        for (int b = 0; b < beats; b++) begin
            e.err = 1'b0;
            e.adr = adr + 32'(4 * b);
            exp_q[n].push_back(e);
        end
        @(posedge clk); #1;
        m_cyc[n] = 1'b1; m_stb[n] = 1'b1; m_we[n] = we;
        m_adr[n] = adr; m_dat_w[n] = dat; m_sel[n] = 4'hF;
        for (int b = 0; b < beats; b++) begin
            got = 1'b0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                got = m_ack[n] | m_err[n];
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL m%0d_beat%0d_wait: got no response required ack", n, b);
            end
            @(posedge clk); #1;
            if (b == beats - 1) begin
                m_cyc[n] = 1'b0; m_stb[n] = 1'b0;
            end else begin
                m_adr[n] = m_adr[n] + 32'd4;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   ncyc;
        bit   got;
        reset = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int n = 0; n < 2; n++) begin
            m_adr[n] = '0; m_dat_w[n] = '0; m_sel[n] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {30'b0, gnt}, 32'd0);
        chk("rst_s_cyc_stb", {30'b0, s_cyc, s_stb}, 32'd0);
        chk("rst_timeout_cnt", {16'b0, timeout_cnt}, 32'd0);
        chk("rst_ack_err", {28'b0, m_ack, m_err}, 32'd0);
        chk("rst_dat_r_passthru", m0_dat_r, 32'hA5A5_0001);
        @(posedge clk); #1;
        reset = 1'b1;
        slave_auto = 1'b1;
        lat = 2;

        // Single m1 write, slave acks two cycles after strobe.
        fork
            master_access(1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 1);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("single_lat_gnt", {30'b0, gnt}, 32'd0);
                chk("single_lat_s_cyc", {31'b0, s_cyc}, 32'd0);
                @(negedge clk);
                chk("single_gnt", {30'b0, gnt}, 32'd2);
                chk("single_s_ctrl", {29'b0, s_cyc, s_stb, s_we}, 32'd7);
                chk("single_s_adr", s_adr, 32'h1000_0004);
                chk("single_s_dat_w", s_dat_w, 32'hDEAD_BEEF);
                chk("single_s_sel", {28'b0, s_sel}, 32'hF);
                @(negedge clk);
                chk("single_no_early_ack", {31'b0, m_ack[1]}, 32'd0);
                @(negedge clk);
                chk("single_ack", {30'b0, m_ack}, 32'd2);
                chk("single_m0_dat_r", m0_dat_r, 32'h1000_0004 ^ K);
            end
        join
        repeat (2) @(posedge clk);

        // Tie from reset pointer, then alternation.
        lat = 0;
        fork
            master_access(0, 1'b0, 32'h0000_0100, 32'h0, 1);
            master_access(1, 1'b0, 32'h0000_0200, 32'h0, 1);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("tie1_idle", {30'b0, gnt}, 32'd0);
                @(negedge clk);
                chk("tie1_m0", {30'b0, gnt}, 32'd1);
                for (int t = 0; t < 20 && gnt != 2'b00; t++) @(negedge clk);
                chk("tie1_gap", {30'b0, gnt}, 32'd0);
                @(negedge clk);
                chk("tie1_m1_next", {30'b0, gnt}, 32'd2);
            end
        join
        repeat (2) @(posedge clk);
        fork
            master_access(0, 1'b0, 32'h0000_0300, 32'h0, 1);
            master_access(1, 1'b0, 32'h0000_0304, 32'h0, 1);
            begin
                @(posedge clk);
                @(negedge clk);
                @(negedge clk);
                chk("tie2_m0", {30'b0, gnt}, 32'd1);
            end
        join
        repeat (2) @(posedge clk);

        // Locked burst: m0 keeps the bus for all four beats.
        lat = 1;
        fork
            master_access(0, 1'b1, 32'h0000_0400, 32'h1234_5678, 4);
            begin
                @(posedge clk); #1;
                master_access(1, 1'b0, 32'h0000_0800, 32'h0, 1);
            end
            begin
                @(posedge clk);
                @(negedge clk);
                for (int t = 0; t < 60 && gnt != 2'b10; t++) @(negedge clk);
                chk("burst_m1_gnt", {30'b0, gnt}, 32'd2);
                chk("burst_m0_released", {31'b0, m_cyc[0]}, 32'd0);
            end
        join
        repeat (2) @(posedge clk);

        // Watchdog abort, then a late ack in ABORT.
        lat = -1;
        e.err = 1'b1; e.adr = 32'h0000_2000;
        exp_q[0].push_back(e);
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h0000_2000;
        ncyc = 0;
        got  = 1'b0;
        for (int t = 0; t < 30 && !got; t++) begin
            @(negedge clk);
            if (gnt == 2'b01) ncyc++;
            got = m_err[0];
        end
        chk("to_err_cycle", 32'(ncyc), 32'd8);
        chk("to_s_forced_low", {30'b0, s_cyc, s_stb}, 32'd0);
        @(posedge clk); #1;
        slave_auto = 1'b0;
        man_ack = 1'b1;
        man_dat = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("to_late_ack_dropped", {30'b0, m_err[0], m_ack[0]}, 32'd0);
        chk("to_count", {16'b0, timeout_cnt}, 32'd1);
        chk("to_abort_s_cyc", {31'b0, s_cyc}, 32'd0);
        @(posedge clk); #1;
        man_ack = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (3) @(posedge clk);

        // Ack on the same cycle the watchdog would expire.
        e.err = 1'b0; e.adr = 32'h0000_3000;
        exp_q[0].push_back(e);
        @(posedge clk); #1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_3000;
        ncyc = 0;
        for (int t = 0; t < 30 && ncyc < 7; t++) begin
            @(negedge clk);
            if (gnt == 2'b01) ncyc++;
        end
        @(posedge clk); #1;
        man_ack = 1'b1;
        man_dat = 32'h0000_3000 ^ K;
        @(negedge clk);
        chk("ackexp_ack_err", {30'b0, m_err[0], m_ack[0]}, 32'd1);
        chk("ackexp_s_cyc", {31'b0, s_cyc}, 32'd1);
        @(posedge clk); #1;
        man_ack = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        chk("ackexp_count_same", {16'b0, timeout_cnt}, 32'd1);
        repeat (2) @(posedge clk);

        // Asynchronous reset while m1 owns with a pending strobe.
        @(posedge clk); #1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_4000;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_gnt", {30'b0, gnt}, 32'd2);
        reset = 1'b0;
        #1;
        chk("midrst_gnt", {30'b0, gnt}, 32'd0);
        chk("midrst_s_cyc_stb", {30'b0, s_cyc, s_stb}, 32'd0);
        chk("midrst_ack_err", {28'b0, m_ack, m_err}, 32'd0);
        chk("midrst_count", {16'b0, timeout_cnt}, 32'd0);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        m_cyc = 2'b11; m_stb = 2'b11;
        @(negedge clk);
        @(negedge clk);
        chk("fresh_tie_m0", {30'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        m_cyc = 2'b00; m_stb = 2'b00;
        @(negedge clk);
        chk("master_abort_no_err", {29'b0, s_cyc, m_err}, 32'd0);
        @(negedge clk);
        chk("master_abort_release", {30'b0, gnt}, 32'd0);

        chk("sb_empty_m0", 32'(exp_q[0].size()), 32'd0);
        chk("sb_empty_m1", 32'(exp_q[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
